// File: rtl/dense_argmax.sv
// dense_argmax: scans NUM_CLASSES signed dense outputs from pixel RAM and reports the index and value of the largest
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   argmax_en       level enable; high runs one scan, low returns to IDLE (also aborts a scan)
//   memstartp       base address of the dense results in pixel RAM
//   qp              signed read data, sampled READ_LATENCY edges after its address is registered
//   re_p            pixel RAM read enable
//   read_addressp   pixel RAM read address (wraps modulo 2^SIZE_address_pix)
//   class_out       0-based index of the maximum score of the last completed scan
//   max_value       maximum score of the last completed scan
//   STOP            scan complete; held while argmax_en stays high
module dense_argmax #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_address_pix = 13,
    parameter int NUM_CLASSES      = 26,
    parameter int READ_LATENCY     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        argmax_en,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_1-1:0]           qp,
    output logic                        re_p,
    output logic [SIZE_address_pix-1:0] read_addressp,
    output logic [4:0]                  class_out,
    output logic [SIZE_1-1:0]           max_value,
    output logic                        STOP
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t                  state;
    logic [4:0]              rd_cnt, cmp_idx, best_idx;
    logic [SIZE_1-1:0]       best;
    // bit i set = a read issued i+1 edges ago is still in flight; the top bit marks qp valid now
    logic [READ_LATENCY-1:0] vpipe;
    logic                    hit;
    assign hit = vpipe[READ_LATENCY-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            re_p          <= 1'b0;
            read_addressp <= '0;
            class_out     <= '0;
            max_value     <= '0;
            STOP          <= 1'b0;
            rd_cnt        <= '0;
            cmp_idx       <= '0;
            best_idx      <= '0;
            best          <= '0;
            vpipe         <= '0;
        end else begin
            // strict greater-than keeps the lower index on ties
            if (hit) begin
                if ($signed(qp) > $signed(best)) begin
                    best     <= qp;
                    best_idx <= cmp_idx;
                end
                cmp_idx <= cmp_idx + 5'd1;
            end
            case (state)
                IDLE: if (argmax_en && !STOP) begin
                    state    <= READ;
                    rd_cnt   <= '0;
                    cmp_idx  <= '0;
                    best     <= {1'b1, {(SIZE_1-1){1'b0}}};
                    best_idx <= '0;
                    vpipe    <= '0;
                end
                READ: if (!argmax_en) begin
                    state <= IDLE;
                    re_p  <= 1'b0;
                    vpipe <= '0;
                end else begin
                    re_p          <= 1'b1;
                    read_addressp <= memstartp + SIZE_address_pix'(rd_cnt);
                    rd_cnt        <= rd_cnt + 5'd1;
                    vpipe         <= (vpipe << 1) | READ_LATENCY'(1);
                    if (rd_cnt == 5'(NUM_CLASSES-1))
                        state <= DRAIN;
                end
                DRAIN: if (!argmax_en) begin
                    state <= IDLE;
                    re_p  <= 1'b0;
                    vpipe <= '0;
                end else begin
                    re_p  <= 1'b0;
                    vpipe <= vpipe << 1;
                    // an empty pipe means the final compare landed on the previous edge
                    if (vpipe == '0) begin
                        state     <= DONE;
                        class_out <= best_idx;
                        max_value <= best;
                        STOP      <= 1'b1;
                    end
                end
                DONE: if (!argmax_en) begin
                    state <= IDLE;
                    STOP  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: directed checks of dense_argmax at read latencies 1, 2 and 3 sharing one RAM image
module tb_dense_argmax;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst, en;
    logic [12:0] ms;
    logic [10:0] ram [0:8191];
    logic        re1, re2, re3, s1, s2, s3;
    logic [12:0] a1, a2, a3, a2d, a3d, a3dd;
    logic [4:0]  c1, c2, c3;
    logic [10:0] m1, m2, m3, q1, q2, q3;
    int checks = 0, errors = 0;
    always @(posedge clk) begin
        a2d  <= a2;
        a3d  <= a3;
        a3dd <= a3d;
    end
    assign q1 = ram[a1];
    assign q2 = ram[a2d];
    assign q3 = ram[a3dd];
    dense_argmax #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .argmax_en(en), .memstartp(ms), .qp(q1),
        .re_p(re1), .read_addressp(a1), .class_out(c1), .max_value(m1), .STOP(s1));
    dense_argmax #(.READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .argmax_en(en), .memstartp(ms), .qp(q2),
        .re_p(re2), .read_addressp(a2), .class_out(c2), .max_value(m2), .STOP(s2));
    dense_argmax #(.READ_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .argmax_en(en), .memstartp(ms), .qp(q3),
        .re_p(re3), .read_addressp(a3), .class_out(c3), .max_value(m3), .STOP(s3));
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run_scan(input string tag, input logic [4:0] ec, input logic [10:0] em);
        int n = 0, t1 = 0, t2 = 0, t3 = 0;
        en = 1'b1;
        tick;
        while (!(s1 && s2 && s3) && n < 60) begin
            tick;
            n++;
            if (s1 && t1 == 0) t1 = n;
            if (s2 && t2 == 0) t2 = n;
            if (s3 && t3 == 0) t3 = n;
            checks++;
            if (n <= 26 ? (re2 !== 1'b1 || a2 !== 13'(ms + n - 1)) : (re2 !== 1'b0)) begin
                errors++;
                $display("FAIL %s addr cycle %0d: re_p=%b addr=%0d, want re_p=%b addr=%0d", tag, n, re2, a2, n <= 26, 13'(ms + n - 1));
            end
        end
        checks += 3;
        if (t1 !== 28) begin errors++; $display("FAIL %s stop_lat1: %0d want 28", tag, t1); end
        if (t2 !== 29) begin errors++; $display("FAIL %s stop_lat2: %0d want 29", tag, t2); end
        if (t3 !== 30) begin errors++; $display("FAIL %s stop_lat3: %0d want 30", tag, t3); end
        checks += 3;
        if (c1 !== ec || m1 !== em) begin errors++; $display("FAIL %s result_lat1: %0d/%0d want %0d/%0d", tag, c1, $signed(m1), ec, $signed(em)); end
        if (c2 !== ec || m2 !== em) begin errors++; $display("FAIL %s result_lat2: %0d/%0d want %0d/%0d", tag, c2, $signed(m2), ec, $signed(em)); end
        if (c3 !== ec || m3 !== em) begin errors++; $display("FAIL %s result_lat3: %0d/%0d want %0d/%0d", tag, c3, $signed(m3), ec, $signed(em)); end
        tick;
        checks++;
        if (s2 !== 1'b1) begin errors++; $display("FAIL %s stop_hold: %b want 1", tag, s2); end
        en = 1'b0;
        tick;
        checks++;
        if (s2 !== 1'b0 || c2 !== ec) begin errors++; $display("FAIL %s stop_release: stop=%b class=%0d want 0/%0d", tag, s2, c2, ec); end
        tick;
    endtask
    task automatic fill_unique(input logic [12:0] base);
        ms = base;
        for (int k = 0; k < 26; k++) ram[13'(base + k)] = 11'(k * 3 - 40);
    endtask
    task automatic test_reset;
        rst = 1'b1; en = 1'b0; ms = '0;
        tick;
        tick;
        rst = 1'b0;
        checks++;
        if (re2 !== 1'b0 || a2 !== 13'd0 || c2 !== 5'd0 || m2 !== 11'd0 || s2 !== 1'b0) begin
            errors++;
            $display("FAIL reset: re=%b addr=%0d class=%0d max=%0d stop=%b want all 0", re2, a2, c2, m2, s2);
        end
    endtask
    task automatic test_unique;
        fill_unique(13'd100);
        run_scan("unique", 5'd25, 11'd35);
    endtask
    task automatic test_reset_midscan;
        en = 1'b1;
        tick;
        repeat (27) tick;
        checks++;
        if (re2 !== 1'b0 || s2 !== 1'b0) begin errors++; $display("FAIL drain_entry: re=%b stop=%b want 0/0", re2, s2); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (re2 !== 1'b0 || a2 !== 13'd0 || c2 !== 5'd0 || m2 !== 11'd0 || s2 !== 1'b0) begin
            errors++;
            $display("FAIL midscan_reset: re=%b addr=%0d class=%0d max=%0d stop=%b want all 0", re2, a2, c2, m2, s2);
        end
        run_scan("after_reset", 5'd25, 11'd35);
    endtask
    task automatic test_abort;
        for (int k = 0; k < 26; k++) ram[13'(ms + k)] = 11'd0;
        ram[13'(ms + 7)]  = 11'd512;
        ram[13'(ms + 19)] = 11'd512;
        en = 1'b1;
        tick;
        repeat (10) tick;
        en = 1'b0;
        tick;
        checks++;
        if (re2 !== 1'b0 || s2 !== 1'b0) begin errors++; $display("FAIL abort_idle: re=%b stop=%b want 0/0", re2, s2); end
        repeat (40) tick;
        checks++;
        if (s1 !== 1'b0 || s2 !== 1'b0 || s3 !== 1'b0) begin errors++; $display("FAIL abort_stop: %b%b%b want 000", s1, s2, s3); end
        checks++;
        if (c2 !== 5'd25 || m2 !== 11'd35) begin errors++; $display("FAIL abort_keep: %0d/%0d want 25/35", c2, $signed(m2)); end
        run_scan("tie_restart", 5'd7, 11'd512);
    endtask
    task automatic test_negative;
        ms = 13'd8180;
        for (int k = 0; k < 26; k++) ram[13'(ms + k)] = 11'(-1023);
        ram[13'(ms + 4)] = 11'(-5);
        run_scan("neg_wrap", 5'd4, 11'(-5));
        for (int k = 0; k < 26; k++) ram[13'(ms + k)] = 11'h400;
        run_scan("all_min", 5'd0, 11'h400);
    endtask
    task automatic test_latency_sweep;
        fill_unique(13'd4000);
        run_scan("sweep", 5'd25, 11'd35);
    endtask
    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = '0;
        test_reset;
        test_unique;
        test_reset_midscan;
        test_abort;
        test_negative;
        test_latency_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dense_argmax.md
Name: dense_argmax

Overview:
- Final classification stage placed directly downstream of the dense layer.
- Once the dense stage raises STOP, the top-level controller enables this block.
- The block reads the NUM_CLASSES dense outputs from pixel RAM starting at memstartp and finds the index of the largest signed score.
- It presents that index as the recognised letter (class) plus a done flag for the top FSM and display logic.

Parameters:
SIZE_1, 11, width of one signed activation word (low SIZE_1 bits of qp)
SIZE_address_pix, 13, pixel RAM address width
NUM_CLASSES, 26, number of dense outputs to scan (1..31)
READ_LATENCY, 2, cycles from read_addressp/re_p registered to qp valid (1..3)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
argmax_en  in  1  level enable; high = run one scan, low = return to IDLE
memstartp  in  SIZE_address_pix  base address of dense results
qp  in  SIZE_1  signed read data from pixel RAM
re_p  out  1  pixel RAM read enable
read_addressp  out  SIZE_address_pix  pixel RAM read address
class_out  out  5  index of maximum score (0-based)
max_value  out  SIZE_1  signed maximum score
STOP  out  1  scan complete; held while argmax_en stays high

Behaviour:
- Reset values (rst=1 at an edge): re_p=0, read_addressp=0, class_out=0, max_value=0, STOP=0, state=IDLE. Internal counters and the valid pipe are cleared.
- States: IDLE, READ, DRAIN, DONE.
- IDLE -> READ: on the first edge with argmax_en=1 and STOP=0.
  - Load rd_cnt=0 and cmp_idx=0.
  - Load best=-2^(SIZE_1-1) and best_idx=0.
- READ: each cycle drive re_p=1 and read_addressp=memstartp+rd_cnt, then rd_cnt++.
  - Push a 1 into a READ_LATENCY-deep valid shift register.
  - After address memstartp+NUM_CLASSES-1 is issued: go to DRAIN, re_p=0.
- DRAIN: push 0s into the valid pipe until it is empty and the last compare is done, then go to DONE.
- Compare: every cycle the pipe output is 1, compare qp with best as signed SIZE_1 values.
  - Strictly greater: best=qp, best_idx=cmp_idx.
  - cmp_idx++ on every valid sample.
  - Ties keep the lower index.
- DONE:
  - On entry, register class_out=best_idx and max_value=best, and set STOP=1.
  - Stay while argmax_en=1, with STOP=1 and re_p=0.
  - argmax_en=0 -> IDLE with STOP=0. class_out and max_value keep the last completed result.
- Latency: STOP rises NUM_CLASSES+READ_LATENCY+1 cycles after the IDLE->READ edge (default 29).
- Abort: argmax_en=0 in READ or DRAIN -> IDLE on the next edge.
  - re_p=0, valid pipe flushed, STOP stays 0.
  - class_out and max_value are not updated.
- rst during any state overrides argmax_en, clears outputs to their reset values and puts the block in IDLE.
- Address arithmetic wraps modulo 2^SIZE_address_pix; no range check.
- Upper bits of memory words above SIZE_1 are ignored by construction; the port is SIZE_1 wide.
- All negative scores: the largest of them is chosen; the initial best is the most negative value, so index 0 holding -2^(SIZE_1-1) still wins.
- Re-run: requires argmax_en low for at least one cycle.
- NUM_CLASSES=1: one read, class_out=0.

Test Plan:
1. Scan with a unique maximum:
   - Stimulus: memstartp=100, RAM[100+k]=k*3-40 for k=0..25, argmax_en held high.
   - Response: addresses 100..125 issued once each on consecutive cycles; STOP at cycle 29; class_out=25; max_value=35.
2. Tie: RAM scores all 0 except indices 7 and 19 = 512 -> class_out=7, max_value=512.
3. All negative: all entries -1023 except index 4 = -5 -> class_out=4, max_value=-5. With all entries -1024 -> class_out=0.
4. Abort: argmax_en dropped at cycle 10 of a scan -> next cycle IDLE, re_p=0, STOP never asserts, class_out/max_value unchanged from the previous run.
   - Re-enable -> full scan restarts at memstartp.
5. Reset mid-scan: rst=1 for one cycle during DRAIN -> outputs at reset values; with argmax_en still high a new scan starts on the following edge.
6. Latency sweep: repeat test 1 with READ_LATENCY=1 and READ_LATENCY=3, RAM model matched -> same class_out/max_value; STOP at cycles 28 and 30.
